// File: rtl/i2s_pkg.sv
// Shared I2S frame timing constants and sample type for the transmit and receive paths.
package i2s_pkg;

    localparam int SCLK_PERIOD     = 36;
    localparam int I2S_PERIOD      = 64;
    localparam int SAMPLE_WIDTH    = 16;
    localparam int I2S_HALF_PERIOD = SCLK_PERIOD / 2;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_transmitter_sample_fifo.sv
// Small synchronous FIFO; pointers wrap naturally because DEPTH is a power of two.
module sample_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LEVEL_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and level are control state.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: derives sclk/ws from the system clock and sends one buffered
// mono sample per frame, MSB-first after the one-bit delay, identically in both slots.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic                    data_valid_in,
    output logic                    data_ready_out,
    output logic                    sclk_out,
    output logic                    ws_out,
    output logic                    sdata_out,
    output logic                    underrun_out
);

    localparam int CW = $clog2(SCLK_PERIOD);
    localparam int FW = $clog2(I2S_PERIOD);
    localparam logic [CW-1:0] SCLK_LAST  = CW'(SCLK_PERIOD - 1);
    localparam logic [CW-1:0] SCLK_RISE  = CW'(I2S_HALF_PERIOD - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(I2S_PERIOD - 1);
    localparam logic [FW-1:0] SLOT_START = FW'(I2S_PERIOD / 2);
    localparam logic [4:0]    LAST_BIT   = 5'(SAMPLE_WIDTH);

    logic [CW-1:0]          sclk_cycle;
    logic [FW-1:0]          cycle;
    logic [FW-1:0]          cycle_next;
    logic [4:0]             h;
    sample_t                frame_sample;
    sample_t                head;
    logic                   fall;
    logic                   frame_load;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [$clog2(FIFO_DEPTH):0] count_unused;

    assign fall       = (sclk_cycle == SCLK_LAST);
    assign frame_load = fall && (cycle == FRAME_LAST);
    assign cycle_next = (cycle == FRAME_LAST) ? '0 : cycle + 1'b1;
    assign h          = cycle_next[4:0];

    assign data_ready_out = !full;
    assign push           = data_valid_in && data_ready_out;
    // The pop sees the pre-edge level, so a push landing on the load edge waits a frame.
    assign pop            = frame_load && !empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(sample_t))
    ) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count_unused)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sclk_cycle   <= SCLK_LAST;
            cycle        <= FRAME_LAST;
            sclk_out     <= 1'b1;
            ws_out       <= 1'b0;
            sdata_out    <= 1'b0;
            underrun_out <= 1'b0;
            frame_sample <= '0;
        end else begin
            underrun_out <= frame_load && empty;
            sclk_cycle   <= fall ? '0 : sclk_cycle + 1'b1;

            if (sclk_cycle == SCLK_RISE) begin
                sclk_out <= 1'b1;
            end else if (fall) begin
                sclk_out <= 1'b0;
            end

            if (fall) begin
                cycle <= cycle_next;
                if (cycle_next == '0) begin
                    ws_out <= 1'b0;
                end else if (cycle_next == SLOT_START) begin
                    ws_out <= 1'b1;
                end
                // Slot bit 0 is the I2S delay bit; bits past the sample are zero padding.
                if (h >= 5'd1 && h <= LAST_BIT) begin
                    sdata_out <= frame_sample[4'(LAST_BIT - h)];
                end else begin
                    sdata_out <= 1'b0;
                end
            end

            if (frame_load) begin
                frame_sample <= empty ? '0 : head;
            end
        end
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S master transmitter for the output DAC path; the playback-side counterpart of the mic I2S receiver.
- Generates sclk/ws from the 100 MHz system clock using the same frame timing as the receive side.
- Buffers 16-bit mono samples from the pitch-correction pipeline in a small FIFO.
- Serialises one sample per frame, MSB-first, identically on left and right channels.

Parameters:
- SCLK_PERIOD, 36, system clocks per sclk period (100e6/(44100*64) rounded up); half period = SCLK_PERIOD/2.
- I2S_PERIOD, 64, sclk periods per frame (two 32-bit slots).
- SAMPLE_WIDTH, 16, bits per sample.
- FIFO_DEPTH, 2, sample buffer entries (power of two, >=2).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous active-high reset.
- data_in  input  SAMPLE_WIDTH  sample to play, two's complement.
- data_valid_in  input  1  data_in is valid this cycle.
- data_ready_out  output  1  FIFO not full; a sample is accepted when valid&&ready.
- sclk_out  output  1  I2S bit clock.
- ws_out  output  1  word select (0 = left, 1 = right).
- sdata_out  output  1  serial data to DAC.
- underrun_out  output  1  one-cycle pulse: frame started with FIFO empty.

Behaviour:
- Reset values: sclk_out=1, ws_out=0, sdata_out=0, underrun_out=0, FIFO empty (data_ready_out=1), sclk_cycle=SCLK_PERIOD-1, cycle=I2S_PERIOD-1, frame sample register=0.
- The first clock after reset deasserts wraps both counters into a new frame (cycle 0).
- sclk_cycle counts 0..SCLK_PERIOD-1 and wraps. sclk goes to 1 when sclk_cycle==SCLK_PERIOD/2-1 and to 0 when sclk_cycle==SCLK_PERIOD-1.
- cycle advances only on the falling-edge event (sclk_cycle==SCLK_PERIOD-1) and wraps from I2S_PERIOD-1 to 0.
- ws_out: on the falling-edge event, set to 0 when wrapping to cycle 0 and to 1 when cycle goes 31->32. ws is therefore 0 for cycles 0..31 and 1 for 32..63.
- Frame load: on the falling-edge event with cycle==I2S_PERIOD-1:
  - if the FIFO is non-empty, pop the head into the frame sample register;
  - if it is empty, load 0 and pulse underrun_out for exactly that cycle.
- sdata_out updates only on the falling-edge event, using the next cycle value n and h = n mod 32:
  - 1<=h<=16: sdata_out = sample[16-h];
  - otherwise: 0 (h=0 is the I2S one-bit delay; h=17..31 is zero padding).
- The same sample is sent in both slots. The DAC samples on the sclk rising edge, mid-bit.
- FIFO:
  - data_ready_out = !full, registered from FIFO state.
  - Push when data_valid_in && data_ready_out. A valid input while not ready is dropped silently.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Push while empty in the same cycle as a frame load: the pop sees empty (underrun, frame plays 0) and the pushed sample is stored for the next frame.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a sample pushed into an empty FIFO before the cycle==63 falling-edge event has its MSB on sdata_out from the cycle-1 edge, i.e. at most one frame plus one sclk later.
- Reset mid-frame: all state returns to reset values, buffered samples are discarded, and no partial bits are emitted after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package i2s_pkg:
  - SCLK_PERIOD, I2S_PERIOD, SAMPLE_WIDTH, I2S_HALF_PERIOD;
  - typedef sample_t (logic [15:0]).
  - The receiver is moved onto the same package.
- One sub-module, sample_fifo: parameterised synchronous FIFO with push/pop/full/empty/count.
- The clock/frame counters and the serialiser stay in the top module.

Test Plan:
- Reset then idle with no input -> sclk period is 36 clocks (high 18 / low 18); ws toggles every 32 sclk; sdata_out constantly 0; underrun_out pulses once per 2304 clocks.
- Push 16'hA5C3 one cycle after reset -> the first frame plays 0 with an underrun. The next frame's left slot, sampled on rising edges at h=1..16, reads 1010010111000011 MSB-first; the right slot reads the same; h=0 and h=17..31 read 0.
- Push 16'h8001, then 16'h7FFE, then 16'h1234 back-to-back -> data_ready_out falls after two accepts. The third is dropped; frames play 8001 then 7FFE, then underrun and 0.
- Hold data_valid_in high continuously with an incrementing value -> exactly one sample consumed per frame; data_ready_out rises for one cycle per frame; no underrun after the first frame.
- Push arriving in the same cycle as the frame-load event with the FIFO empty -> underrun_out=1 and that frame outputs 0; the pushed sample plays in the following frame.
- Assert rst_in for one cycle mid-frame (cycle≈40) with two samples buffered -> outputs return to reset values on the next clock; FIFO empty; the next frame underruns.
